mem_bridge: RTL and testbench

Memory-side stage between the core datapath's load/store port and a single-port synchronous word SRAM. It registers a byte-addressed request of size byte, half or word. It then issues word-aligned SRAM accesses with byte enables and lane steering, and returns right-aligned, zero-extended read data. Sign extension stays in the datapath. A valid/ready request handshake lets the control FSM stall until the response arrives.

---
 rtl/mem_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: registers one byte-addressed load/store and runs it against a single-port word SRAM.
// Define MEM_BRIDGE_MISALIGNED_EN to split word-crossing accesses into two SRAM cycles; otherwise they respond with an error.
module mem_bridge #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [3:0]        sram_be_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            2'd2:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
        crosses_word = (({2'b00, off} + {1'b0, size_bytes(size)}) > 4'd4);
    endfunction

    // Byte-lane mask over the two-word window; hi selects the second word's lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off, input logic hi);
        logic [7:0] base;
        logic [7:0] m;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        m = base << off;
        lane_mask = hi ? m[7:4] : m[3:0];
    endfunction

    function automatic logic [31:0] rotate_lanes(input logic [31:0] d, input logic [1:0] off);
        case (off)
            2'd0:    rotate_lanes = d;
            2'd1:    rotate_lanes = {d[23:0], d[31:24]};
            2'd2:    rotate_lanes = {d[15:0], d[31:16]};
            default: rotate_lanes = {d[7:0], d[31:8]};
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off, input logic [1:0] size);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (size)
            2'd0:    extract = {24'h000000, sh[7:0]};
            2'd1:    extract = {16'h0000, sh[15:0]};
            2'd2:    extract = sh[31:0];
            default: extract = 32'h00000000;
        endcase
    endfunction

    state_t              state_r, state_s;
    logic                we_r;
    logic [1:0]          size_r;
    logic [1:0]          off_r;
    logic                ready_r, ready_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic                rsp_err_r, rsp_err_s;
    logic                en_r, en_s;
    logic                swe_r, swe_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [3:0]          be_r, be_s;
    logic [31:0]         wdata_r, wdata_s;
    logic                illegal_s;
    logic [63:0]         pair_s;
    logic                unused_addr_s;
`ifdef MEM_BRIDGE_MISALIGNED_EN
    logic                split_r;
    logic [ADDR_W-1:0]   word_r;
    logic [31:0]         rot_r;
    logic [31:0]         lo_word_r;
`endif

    // Upper byte-address bits beyond the SRAM are ignored by design.
    assign unused_addr_s = ^req_addr_i[31:ADDR_W+2];

`ifdef MEM_BRIDGE_MISALIGNED_EN
    assign illegal_s = (req_size_i == 2'd3);
`else
    assign illegal_s = (req_size_i == 2'd3) || crosses_word(req_size_i, req_addr_i[1:0]);
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        ready_s     = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        en_s        = 1'b0;
        swe_s       = 1'b0;
        addr_s      = '0;
        be_s        = 4'h0;
        wdata_s     = 32'h00000000;
        case (state_r)
            IDLE: begin
                if (req_valid_i) begin
                    if (illegal_s) begin
                        state_s     = RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                    end else begin
                        state_s = ACC1;
                        en_s    = 1'b1;
                        swe_s   = req_we_i;
                        addr_s  = req_addr_i[ADDR_W+1:2];
                        be_s    = req_we_i ? lane_mask(req_size_i, req_addr_i[1:0], 1'b0) : 4'hF;
                        wdata_s = req_we_i ? rotate_lanes(req_wdata_i, req_addr_i[1:0]) : 32'h00000000;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            ACC1: begin
`ifdef MEM_BRIDGE_MISALIGNED_EN
                if (split_r) begin
                    state_s = ACC2;
                    en_s    = 1'b1;
                    swe_s   = we_r;
                    addr_s  = word_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    be_s    = we_r ? lane_mask(size_r, off_r, 1'b1) : 4'hF;
                    wdata_s = we_r ? rot_r : 32'h00000000;
                end else begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                end
`else
                state_s     = RESP;
                rsp_valid_s = 1'b1;
`endif
            end
`ifdef MEM_BRIDGE_MISALIGNED_EN
            ACC2: begin
                state_s     = RESP;
                rsp_valid_s = 1'b1;
            end
`endif
            RESP: begin
                state_s = IDLE;
                ready_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, request capture and registered outputs; reset drops any in-flight access.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            size_r      <= 2'd0;
            off_r       <= 2'd0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            en_r        <= 1'b0;
            swe_r       <= 1'b0;
            addr_r      <= '0;
            be_r        <= 4'h0;
            wdata_r     <= 32'h00000000;
`ifdef MEM_BRIDGE_MISALIGNED_EN
            split_r     <= 1'b0;
            word_r      <= '0;
            rot_r       <= 32'h00000000;
            lo_word_r   <= 32'h00000000;
`endif
        end else begin
            state_r     <= state_s;
            ready_r     <= ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            en_r        <= en_s;
            swe_r       <= swe_s;
            addr_r      <= addr_s;
            be_r        <= be_s;
            wdata_r     <= wdata_s;
            if (state_r == IDLE && req_valid_i) begin
                we_r   <= req_we_i;
                size_r <= req_size_i;
                off_r  <= req_addr_i[1:0];
`ifdef MEM_BRIDGE_MISALIGNED_EN
                split_r <= crosses_word(req_size_i, req_addr_i[1:0]);
                word_r  <= req_addr_i[ADDR_W+1:2];
                rot_r   <= rotate_lanes(req_wdata_i, req_addr_i[1:0]);
`endif
            end
`ifdef MEM_BRIDGE_MISALIGNED_EN
            if (state_r == ACC2) begin
                lo_word_r <= sram_rdata_i;
            end
`endif
        end
    end

    // Read data arrives from the SRAM in the response cycle itself, so it is steered here.
    always_comb begin
        pair_s = {32'h00000000, sram_rdata_i};
`ifdef MEM_BRIDGE_MISALIGNED_EN
        if (split_r) begin
            pair_s = {sram_rdata_i, lo_word_r};
        end else begin
            pair_s = {32'h00000000, sram_rdata_i};
        end
`endif
        if (rsp_valid_r && !rsp_err_r && !we_r) begin
            rsp_rdata_o = extract(pair_s, off_r, size_r);
        end else begin
            rsp_rdata_o = 32'h00000000;
        end
    end

    assign req_ready_o  = ready_r;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_err_o    = rsp_err_r;
    assign sram_en_o    = en_r;
    assign sram_we_o    = swe_r;
    assign sram_addr_o  = addr_r;
    assign sram_be_o    = be_r;
    assign sram_wdata_o = wdata_r;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed stimulus against a byte-level memory model and a behavioural SRAM.
// Expected strobes and responses follow the bridge's timing rules; MEM_BRIDGE_MISALIGNED_EN selects the split-access expectations.
module tb_mem_bridge;
    localparam int ADDR_W = 14;
    localparam int NWORDS = 1 << ADDR_W;
    localparam int BMASK  = NWORDS * 4 - 1;
`ifdef MEM_BRIDGE_MISALIGNED_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_i = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [31:0]       req_addr_i = 32'h0;
    logic [1:0]        req_size_i = 2'd0;
    logic [31:0]       req_wdata_i = 32'h0;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              sram_en_o;
    logic              sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [3:0]        sram_be_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata_i = 32'h0;

    always #5 clk = ~clk;

    mem_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    logic [31:0] sram [0:NWORDS-1];
    always @(posedge clk) begin
        if (sram_en_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram[sram_addr_o];
            end
        end
    end

    typedef struct { logic [ADDR_W-1:0] addr; logic [3:0] be; logic we; logic [31:0] wd; } stb_t;
    typedef struct { logic err; logic [31:0] data; } rsp_t;

    logic [7:0] bmodel [int];
    stb_t exp_stb [int];
    rsp_t exp_rsp [int];
    int edge_n = 0, busy_from = 0, busy_to = -1, acc_edge = 0, n_acc = 0;
    int n_tests = 0, n_fail = 0;
    int obs_n_stb = 0, obs_rsp_edge = -1, en_cycles = 0, err_rsps = 0;
    logic [ADDR_W-1:0] obs_addr [2];
    logic [3:0]        obs_be [2];
    logic [31:0]       obs_wd [2];
    logic [31:0]       obs_rdata = 32'h0;
    logic              obs_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Spec-level model of one accepted request: lanes, strobe cycles, response cycle and data.
    task automatic model_accept(input int e, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic [31:0] wd);
        int off, nb, word, r;
        logic [7:0] m;
        logic [63:0] rot64;
        logic [31:0] data;
        off  = int'(addr[1:0]);
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        word = int'(addr >> 2) & (NWORDS - 1);
        acc_edge = e; busy_from = e; n_acc++;
        obs_n_stb = 0; obs_rsp_edge = -1;
        if (size == 2'd3 || (!MIS && off + nb > 4)) begin
            exp_rsp[e] = '{1'b1, 32'h0};
            busy_to = e;
        end else begin
            m = 8'(((1 << nb) - 1) << off);
            rot64 = {wd, wd} << (8 * off);
            exp_stb[e] = '{ADDR_W'(word), we ? m[3:0] : 4'hF, we, rot64[63:32]};
            r = e + 1;
            if (off + nb > 4) begin
                exp_stb[e+1] = '{ADDR_W'((word + 1) % NWORDS), we ? m[7:4] : 4'hF, we, rot64[63:32]};
                r = e + 2;
            end
            data = 32'h0;
            for (int i = 0; i < nb; i++) begin
                if (we) bmodel[(int'(addr) + i) & BMASK] = wd[8*i +: 8];
                else if (bmodel.exists((int'(addr) + i) & BMASK))
                    data = data | (32'(bmodel[(int'(addr) + i) & BMASK]) << (8 * i));
            end
            exp_rsp[r] = '{1'b0, data};
            busy_to = r;
        end
    endtask

    // Edge monitor: counts edges, sees accepts and reset.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (!reset_i) begin
                foreach (exp_stb[k]) if (k >= edge_n) exp_stb.delete(k);
                foreach (exp_rsp[k]) if (k >= edge_n) exp_rsp.delete(k);
                busy_to = -1;
            end else if (req_valid_i && req_ready_o) begin
                model_accept(edge_n, req_we_i, req_addr_i, req_size_i, req_wdata_i);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                chk("ready", req_ready_o, !(edge_n >= busy_from && edge_n <= busy_to));
                chk("sram_en", sram_en_o, exp_stb.exists(edge_n));
                if (exp_stb.exists(edge_n)) begin
                    chk("sram_addr", sram_addr_o, exp_stb[edge_n].addr);
                    chk("sram_be", sram_be_o, exp_stb[edge_n].be);
                    chk("sram_we", sram_we_o, exp_stb[edge_n].we);
                    if (exp_stb[edge_n].we) chk("sram_wdata", sram_wdata_o, exp_stb[edge_n].wd);
                end
                chk("rsp_valid", rsp_valid_o, exp_rsp.exists(edge_n));
                if (exp_rsp.exists(edge_n)) begin
                    chk("rsp_err", rsp_err_o, exp_rsp[edge_n].err);
                    chk("rsp_rdata", rsp_rdata_o, exp_rsp[edge_n].data);
                end
                if (sram_en_o) begin
                    en_cycles++;
                    if (obs_n_stb < 2) begin
                        obs_addr[obs_n_stb] = sram_addr_o;
                        obs_be[obs_n_stb]   = sram_be_o;
                        obs_wd[obs_n_stb]   = sram_wdata_o;
                    end
                    obs_n_stb++;
                end
                if (rsp_valid_o) begin
                    obs_rsp_edge = edge_n;
                    obs_rdata    = rsp_rdata_o;
                    obs_err      = rsp_err_o;
                    if (rsp_err_o) err_rsps++;
                end
            end
        end
    end

    task automatic wait_accept();
        int start;
        bit got;
        start = n_acc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = (n_acc != start);
        end
        chk("accept", got, 1'b1);
        req_valid_i = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_size_i = size; req_wdata_i = wd;
        wait_accept();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (edge_n > busy_to) break;
        end
    endtask

    function automatic int lat();
        return obs_rsp_edge - acc_edge + 1;
    endfunction

    initial begin
        int e0, r0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_sram_addr", sram_addr_o, '0);
        chk("rst_sram_be", sram_be_o, 4'h0);
        chk("rst_sram_wdata", sram_wdata_o, 32'h0);
        reset_i = 1'b1;

        do_req(1'b1, 32'h10, 2'd2, 32'hDEADBEEF);
        chk("st_w_addr", obs_addr[0], ADDR_W'(4));
        chk("st_w_be", obs_be[0], 4'hF);
        chk("st_w_wd", obs_wd[0], 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 2'd2, 32'h0);
        chk("ld_w_lat", lat(), 2);
        chk("ld_w_data", obs_rdata, 32'hDEADBEEF);
        chk("ld_w_err", obs_err, 1'b0);

        do_req(1'b1, 32'h13, 2'd0, 32'h000000A5);
        chk("st_b_be", obs_be[0], 4'h8);
        chk("st_b_wd", obs_wd[0], 32'hA5000000);
        do_req(1'b0, 32'h13, 2'd0, 32'h0);
        chk("ld_b_data", obs_rdata, 32'h000000A5);
        do_req(1'b0, 32'h10, 2'd2, 32'h0);
        chk("ld_w_merge", obs_rdata, 32'hA5ADBEEF);

        do_req(1'b1, 32'h10, 2'd2, 32'h11223344);
        do_req(1'b1, 32'h14, 2'd2, 32'h55667788);
        do_req(1'b0, 32'h13, 2'd1, 32'h0);
        if (MIS) begin
            chk("split_nstb", obs_n_stb, 2);
            chk("split_addr0", obs_addr[0], ADDR_W'(4));
            chk("split_addr1", obs_addr[1], ADDR_W'(5));
            chk("split_lat", lat(), 3);
            chk("split_data", obs_rdata, 32'h00008811);
        end else begin
            chk("mis_nstb", obs_n_stb, 0);
            chk("mis_lat", lat(), 1);
            chk("mis_err", obs_err, 1'b1);
            chk("mis_data", obs_rdata, 32'h0);
        end

        do_req(1'b1, 32'h11, 2'd1, 32'h0000BEEF);
        chk("st_h_be", obs_be[0], 4'h6);
        chk("st_h_wd", obs_wd[0], 32'h00BEEF00);
        do_req(1'b0, 32'h10, 2'd2, 32'h0);
        chk("ld_h_merge", obs_rdata, 32'h11BEEF44);
        do_req(1'b0, 32'h11, 2'd1, 32'h0);
        chk("ld_h_mid", obs_rdata, 32'h0000BEEF);

        do_req(1'b1, 32'hFFFC, 2'd2, 32'hCAFEF00D);
        do_req(1'b1, 32'h0, 2'd2, 32'h01234567);
        do_req(1'b0, 32'hFFFF, 2'd2, 32'h0);
        if (MIS) begin
            chk("wrap_addr0", obs_addr[0], ADDR_W'(NWORDS - 1));
            chk("wrap_addr1", obs_addr[1], ADDR_W'(0));
            chk("wrap_data", obs_rdata, 32'h234567CA);
        end else begin
            chk("wrap_err", obs_err, 1'b1);
        end

        e0 = en_cycles; r0 = err_rsps;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h20; req_size_i = 2'd3;
        repeat (10) @(negedge clk);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("sz3_no_strobe", en_cycles - e0, 0);
        chk("sz3_err_count", err_rsps - r0, 5);

        // Store interrupted by reset while its last strobe is on the bus.
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_wdata_i = 32'h0BADF00D;
        req_addr_i = MIS ? 32'h21 : 32'h20;
        wait_accept();
        @(negedge clk);
        if (MIS) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", req_ready_o, 1'b1);
        chk("rst_mid_nrsp", obs_rsp_edge, -1);
        chk("rst_mid_nstb", obs_n_stb, MIS ? 2 : 1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
